// File: rtl/pc_stack_unit.sv
// Program counter with an integrated hardware return-address stack (CALL pushes PC+1, RET pops).
// Optional macro PC_STK_CIRC_EN: overflow PUSH overwrites the oldest entry instead of flagging an error.
module pc_stack_unit #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    input  logic             pc_ld,
    input  logic             pc_inc,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] pc_count,
    output logic [WIDTH-1:0] stk_top,
    output logic             stk_empty,
    output logic             stk_full,
    output logic             stk_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] SP_MAX = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] stk_mem [DEPTH];
    logic [PW:0]      sp;
    logic [PW-1:0]    wr_idx;
    logic [PW-1:0]    top_idx;
    logic [WIDTH-1:0] ret_addr;

    assign ret_addr = pc_count + WIDTH'(1);

    // wr_idx always points one past the top; with an empty stack the
    // non-circular build falls back to index 0 (last value held there).
`ifdef PC_STK_CIRC_EN
    assign top_idx = wr_idx - PW'(1);
`else
    assign top_idx = (sp == '0) ? '0 : wr_idx - PW'(1);
`endif

    assign stk_top   = stk_mem[top_idx];
    assign stk_empty = (sp == '0);
    assign stk_full  = (sp == SP_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_count <= '0;
            sp       <= '0;
            wr_idx   <= '0;
            stk_err  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stk_mem[i] <= '0;
            end
        end else begin
            if (pc_ld) begin
                pc_count <= d_in;
            end else if (pc_inc) begin
                pc_count <= pc_count + WIDTH'(1);
            end

            if (push && pop) begin
                stk_err <= 1'b1;
            end else if (push) begin
                if (sp == SP_MAX) begin
`ifdef PC_STK_CIRC_EN
                    stk_mem[wr_idx] <= ret_addr;
                    wr_idx          <= wr_idx + PW'(1);
`else
                    stk_err <= 1'b1;
`endif
                end else begin
                    stk_mem[wr_idx] <= ret_addr;
                    wr_idx          <= wr_idx + PW'(1);
                    sp              <= sp + (PW + 1)'(1);
                end
            end else if (pop) begin
                if (sp == '0) begin
                    stk_err <= 1'b1;
                end else begin
                    wr_idx <= wr_idx - PW'(1);
                    sp     <= sp - (PW + 1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Table-driven bench for pc_stack_unit (WIDTH=10, DEPTH=8), plus hand-written corner sequences.
module tb_pc_stack_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] d_in;
    logic       pc_ld, pc_inc, push, pop;
    logic [9:0] pc_count, stk_top;
    logic       stk_empty, stk_full, stk_err;

    int compared   = 0;
    int mismatched = 0;

    pc_stack_unit #(.WIDTH(10), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .pc_ld(pc_ld), .pc_inc(pc_inc),
        .push(push), .pop(pop), .pc_count(pc_count), .stk_top(stk_top),
        .stk_empty(stk_empty), .stk_full(stk_full), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [9:0] din;
        logic       ld, inc, psh, pp;
        logic [9:0] pc, top;
        logic       em, fu, er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [9:0] di, input logic l, input logic i,
                                input logic ps, input logic po, input logic [9:0] p, input logic [9:0] t,
                                input logic e, input logic f, input logic x);
        vec_t v;
        v.rst = r; v.din = di; v.ld = l; v.inc = i; v.psh = ps; v.pp = po;
        v.pc = p; v.top = t; v.em = e; v.fu = f; v.er = x;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        rst = v.rst; d_in = v.din; pc_ld = v.ld; pc_inc = v.inc; push = v.psh; pop = v.pp;
        @(posedge clk);
        #1;
        compared++;
        if ({pc_count, stk_top, stk_empty, stk_full, stk_err} !== {v.pc, v.top, v.em, v.fu, v.er}) begin
            mismatched++;
            $display("FAIL %s: got pc=%h top=%h empty=%b full=%b err=%b, want pc=%h top=%h empty=%b full=%b err=%b",
                     name, pc_count, stk_top, stk_empty, stk_full, stk_err,
                     v.pc, v.top, v.em, v.fu, v.er);
        end
    endtask

    initial begin
        rst = 1'b1; d_in = '0; pc_ld = 0; pc_inc = 0; push = 0; pop = 0;

        //            rst din    ld inc ps po  pc     top    em fu er
        vecs.push_back(mk(1, 10'h000, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0)); // reset
        vecs.push_back(mk(0, 10'h000, 0, 1, 0, 0, 10'h001, 10'h000, 1, 0, 0));
        vecs.push_back(mk(0, 10'h000, 0, 1, 0, 0, 10'h002, 10'h000, 1, 0, 0));
        vecs.push_back(mk(0, 10'h000, 0, 1, 0, 0, 10'h003, 10'h000, 1, 0, 0));
        vecs.push_back(mk(0, 10'h3FF, 1, 1, 0, 0, 10'h3FF, 10'h000, 1, 0, 0)); // load beats inc
        vecs.push_back(mk(0, 10'h000, 0, 1, 0, 0, 10'h000, 10'h000, 1, 0, 0)); // wrap
        vecs.push_back(mk(0, 10'h010, 1, 0, 0, 0, 10'h010, 10'h000, 1, 0, 0));
        vecs.push_back(mk(0, 10'h200, 1, 0, 1, 0, 10'h200, 10'h011, 0, 0, 0)); // call
        vecs.push_back(mk(0, 10'h011, 1, 0, 0, 1, 10'h011, 10'h011, 1, 0, 0)); // return
        vecs.push_back(mk(0, 10'h000, 0, 0, 0, 0, 10'h011, 10'h011, 1, 0, 0)); // hold
        vecs.push_back(mk(0, 10'h000, 0, 0, 0, 1, 10'h011, 10'h011, 1, 0, 1)); // underflow
        vecs.push_back(mk(0, 10'h000, 0, 0, 0, 0, 10'h011, 10'h011, 1, 0, 1)); // sticky
        vecs.push_back(mk(1, 10'h000, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(0, 10'h000, 0, 1, 1, 0, 10'(k), 10'(k), 0, (k == 8), 0));
        vecs.push_back(mk(0, 10'h020, 1, 0, 0, 0, 10'h020, 10'h008, 0, 1, 0));
`ifdef PC_STK_CIRC_EN
        vecs.push_back(mk(0, 10'h000, 0, 0, 1, 0, 10'h020, 10'h021, 0, 1, 0)); // overwrite oldest
        vecs.push_back(mk(0, 10'h000, 0, 0, 0, 1, 10'h020, 10'h008, 0, 0, 0));
`else
        vecs.push_back(mk(0, 10'h000, 0, 0, 1, 0, 10'h020, 10'h008, 0, 1, 1)); // overflow dropped
        vecs.push_back(mk(0, 10'h000, 0, 0, 0, 1, 10'h020, 10'h007, 0, 0, 1));
`endif
        vecs.push_back(mk(1, 10'h000, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0));
        vecs.push_back(mk(0, 10'h000, 0, 0, 1, 0, 10'h000, 10'h001, 0, 0, 0));
        vecs.push_back(mk(0, 10'h000, 0, 0, 1, 1, 10'h000, 10'h001, 0, 0, 1)); // push+pop illegal
        vecs.push_back(mk(0, 10'h000, 0, 0, 0, 1, 10'h000, 10'h001, 1, 0, 1)); // still works
        vecs.push_back(mk(0, 10'h000, 0, 0, 1, 0, 10'h000, 10'h001, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // Reset mid-call overrides PUSH and PC_LD.
        apply(mk(0, 10'h050, 1, 0, 0, 0, 10'h050, 10'h001, 0, 0, 1), "pre_rst_ld");
        apply(mk(1, 10'h200, 1, 0, 1, 0, 10'h000, 10'h000, 1, 0, 0), "rst_mid_call");

        // Return address wraps when calling from the last PC; reset mid-return.
        apply(mk(0, 10'h3FF, 1, 0, 0, 0, 10'h3FF, 10'h000, 1, 0, 0), "ld_3ff");
        apply(mk(0, 10'h100, 1, 0, 1, 0, 10'h100, 10'h000, 0, 0, 0), "call_wrap");
        apply(mk(0, 10'h000, 0, 1, 1, 0, 10'h101, 10'h101, 0, 0, 0), "nested_call");
        apply(mk(0, 10'h101, 1, 0, 0, 1, 10'h101, 10'h000, 0, 0, 0), "ret_inner");
        apply(mk(1, 10'h000, 1, 0, 0, 1, 10'h000, 10'h000, 1, 0, 0), "rst_mid_ret");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
